// File: rtl/ysyx_25040109_pkg.sv
// Shared types and constants for the ysyx_25040109 fetch unit.
package ysyx_25040109_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    WAIT_R  = 3'd2,
    OUT     = 3'd3,
    WAIT_PC = 3'd4
  } ifu_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [1:0]  RRESP_OKAY       = 2'b00;

  // A fetch address is usable only when it sits on a 4-byte boundary.
  function automatic logic is_word_aligned(input logic [1:0] addr_lo);
    return addr_lo == 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_25040109_reg.sv
// Generic register with write enable and a parameterised reset value.
module ysyx_25040109_Reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wen,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Hold value unless written; return to RESET_VAL on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignment so every flop samples pre-edge values.
    if (!rst_n)   q <= RESET_VAL;
    else if (wen) q <= d;
  end

endmodule

// File: rtl/ysyx_25040109_ifu.sv
// Instruction fetch unit: one outstanding read at a time, PC supplied by write-back.
module ysyx_25040109_ifu
  import ysyx_25040109_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ifu_arvalid,
  output logic [31:0] ifu_araddr,
  input  logic        ifu_arready,
  input  logic        ifu_rvalid,
  input  logic [31:0] ifu_rdata,
  input  logic [1:0]  ifu_rresp,
  output logic        ifu_rready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        out_fault,
  input  logic        pc_upd_valid,
  input  logic [31:0] pc_upd
);

  ifu_state_e  state, state_nxt;
  logic [31:0] pc;
  logic        pc_wen;
  logic        upd_aligned;

  // The PC only moves when write-back hands over a new value in WAIT_PC.
  assign pc_wen      = (state == WAIT_PC) && pc_upd_valid;
  assign upd_aligned = is_word_aligned(pc_upd[1:0]);

  ysyx_25040109_Reg #(
    .WIDTH     (32),
    .RESET_VAL (RESET_PC)
  ) u_pc_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .wen   (pc_wen),
    .d     (pc_upd),
    .q     (pc)
  );

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = FETCH;
      FETCH:   if (ifu_arready)  state_nxt = WAIT_R;
      WAIT_R:  if (ifu_rvalid)   state_nxt = OUT;
      OUT:     if (out_ready)    state_nxt = WAIT_PC;
      WAIT_PC: if (pc_upd_valid) state_nxt = upd_aligned ? FETCH : OUT;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore handshake outputs: a single state owns each, so they never overlap.
  assign ifu_arvalid = (state == FETCH);
  assign ifu_rready  = (state == WAIT_R);
  assign out_valid   = (state == OUT);
  assign ifu_araddr  = pc;
  assign out_pc      = pc;

  // Packet capture: bus data in WAIT_R, or a synthesised fault for a misaligned PC.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: these are control-visible packet registers (not a storage array), so they get a defined reset.
    if (!rst_n) begin
      out_inst  <= 32'h0;
      out_fault <= 1'b0;
    end else if ((state == WAIT_R) && ifu_rvalid) begin
      out_inst  <= ifu_rdata;
      out_fault <= (ifu_rresp != RRESP_OKAY);
    end else if (pc_wen && !upd_aligned) begin
      out_inst  <= 32'h0;
      out_fault <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ysyx_25040109_ifu.sv
// Scoreboard bench for the fetch unit: the driver plays memory, decode and write-back.
module tb_ysyx_25040109_ifu;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
  } pkt_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifu_arvalid;
  logic [31:0] ifu_araddr;
  logic        ifu_arready;
  logic        ifu_rvalid;
  logic [31:0] ifu_rdata;
  logic [1:0]  ifu_rresp;
  logic        ifu_rready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_fault;
  logic        pc_upd_valid;
  logic [31:0] pc_upd;

  int          n_checks = 0;
  int          n_errors = 0;
  int          hs_count = 0;
  int          exp_hs   = 0;
  logic [31:0] model_pc;
  pkt_t        exp_q[$];

  always #5 clk = ~clk;

  ysyx_25040109_ifu #(.RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ifu_arvalid  (ifu_arvalid),
    .ifu_araddr   (ifu_araddr),
    .ifu_arready  (ifu_arready),
    .ifu_rvalid   (ifu_rvalid),
    .ifu_rdata    (ifu_rdata),
    .ifu_rresp    (ifu_rresp),
    .ifu_rready   (ifu_rready),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_inst     (out_inst),
    .out_pc       (out_pc),
    .out_fault    (out_fault),
    .pc_upd_valid (pc_upd_valid),
    .pc_upd       (pc_upd)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle a packet is presented it must match the queue head.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_packet: got pc %h inst %h with nothing expected", out_pc, out_inst);
      end else begin
        check("pkt_inst",  out_inst,  exp_q[0].inst);
        check("pkt_pc",    out_pc,    exp_q[0].pc);
        check("pkt_fault", out_fault, exp_q[0].fault);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Count address handshakes seen on the bus.
  always @(negedge clk) begin
    if (rst_n && ifu_arvalid && ifu_arready) hs_count++;
  end

  // One instruction: optional bus fetch, packet hand-off, then next-PC delivery.
  task automatic run_txn(input int ar_dly, input int r_dly, input logic [31:0] rdata,
                         input logic [1:0] rresp, input int rdy_dly, input int pc_dly,
                         input logic [31:0] next_pc);
    int n;
    if (model_pc[1:0] == 2'b00) begin
      n = 0;
      while (!ifu_arvalid && n < 20) begin step(); n++; end
      check("arvalid_up", ifu_arvalid, 1);
      exp_hs++;
      for (int i = 0; i <= ar_dly; i++) begin
        check("araddr", ifu_araddr, model_pc);
        check("arvalid_hold", ifu_arvalid, 1);
        if (i == ar_dly) ifu_arready = 1'b1;
        step();
      end
      ifu_arready = 1'b0;
      check("arvalid_drop", ifu_arvalid, 0);
      for (int i = 0; i < r_dly; i++) begin
        check("rready_wait", ifu_rready, 1);
        check("no_early_out", out_valid, 0);
        step();
      end
      check("rready", ifu_rready, 1);
      exp_q.push_back('{inst: rdata, pc: model_pc, fault: (rresp != 2'b00)});
      ifu_rvalid = 1'b1;
      ifu_rdata  = rdata;
      ifu_rresp  = rresp;
      step();
      ifu_rvalid = 1'b0;
      ifu_rdata  = $urandom;
      ifu_rresp  = 2'b00;
      check("latency_out_valid", out_valid, 1);
    end else begin
      check("misaligned_no_fetch", ifu_arvalid, 0);
      check("misaligned_out", out_valid, 1);
    end

    n = 0;
    while (!out_valid && n < 20) begin step(); n++; end
    check("out_valid_up", out_valid, 1);
    // Decode stalls; junk PC updates and read data must be ignored meanwhile.
    for (int i = 0; i < rdy_dly; i++) begin
      check("no_req_in_out", ifu_arvalid, 0);
      pc_upd_valid = (i % 2 == 0);
      pc_upd       = $urandom;
      ifu_rvalid   = 1'($urandom_range(0, 1));
      ifu_rdata    = $urandom;
      step();
    end
    pc_upd_valid = 1'b0;
    ifu_rvalid   = 1'b0;
    out_ready    = 1'b1;
    step();
    out_ready = 1'b0;
    check("accept_out_drop", out_valid, 0);
    check("wait_pc_no_req", ifu_arvalid, 0);
    check("pc_hold", out_pc, model_pc);

    repeat (pc_dly) step();
    pc_upd_valid = 1'b1;
    pc_upd       = next_pc;
    model_pc     = next_pc;
    if (next_pc[1:0] != 2'b00) exp_q.push_back('{inst: 32'h0, pc: next_pc, fault: 1'b1});
    step();
    pc_upd_valid = 1'b0;
    pc_upd       = $urandom;
    check("pc_load", out_pc, model_pc);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] np;
    logic [1:0]  rr;
    rst_n        = 1'b0;
    ifu_arready  = 1'b0;
    ifu_rvalid   = 1'b0;
    ifu_rdata    = 32'h0;
    ifu_rresp    = 2'b00;
    out_ready    = 1'b0;
    pc_upd_valid = 1'b0;
    pc_upd       = 32'h0;
    model_pc     = RST_PC;

    repeat (2) step();
    check("rst_arvalid", ifu_arvalid, 0);
    check("rst_rready", ifu_rready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_pc", out_pc, RST_PC);
    check("rst_inst", out_inst, 0);
    check("rst_fault", out_fault, 0);

    rst_n = 1'b1;
    check("idle_no_req", ifu_arvalid, 0);
    step();
    check("fetch_after_reset", ifu_arvalid, 1);

    // Directed: zero-wait fetch, then aligned redirect.
    run_txn(0, 0, 32'h0010_0093, 2'b00, 0, 0, 32'h8000_0010);
    // Directed: address stall of 3, decode stall of 5, then a misaligned redirect.
    run_txn(3, 1, 32'h1234_5678, 2'b00, 5, 1, 32'h8000_0012);
    // Misaligned PC produces a fault packet with no bus traffic.
    run_txn(0, 0, 32'h0, 2'b00, 2, 0, 32'h8000_0020);
    // Non-OKAY response keeps the data but flags a fault.
    run_txn(1, 2, 32'hdead_beef, 2'b10, 0, 0, 32'h8000_0024);

    for (int t = 0; t < 40; t++) begin
      np = 32'h8000_0000 + ($urandom_range(0, 255) << 2);
      if (t != 39 && $urandom_range(0, 3) == 0) np[1:0] = 2'($urandom_range(1, 3));
      rr = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      run_txn($urandom_range(0, 3), $urandom_range(0, 3), $urandom, rr,
              $urandom_range(0, 4), $urandom_range(0, 2), np);
    end

    // Reset while waiting for read data; the late response must be dropped.
    begin
      int n = 0;
      while (!ifu_arvalid && n < 20) begin step(); n++; end
      check("pre_abort_arvalid", ifu_arvalid, 1);
      exp_hs++;
      ifu_arready = 1'b1;
      step();
      ifu_arready = 1'b0;
      check("pre_abort_rready", ifu_rready, 1);
    end
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    model_pc = RST_PC;
    check("abort_rready", ifu_rready, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_pc", out_pc, RST_PC);
    check("abort_inst", out_inst, 0);
    check("abort_fault", out_fault, 0);
    ifu_rvalid = 1'b1;
    ifu_rdata  = 32'hbad0_0bad;
    ifu_rresp  = 2'b11;
    repeat (2) step();
    rst_n = 1'b1;
    check("abort_idle", ifu_arvalid, 0);
    step();
    ifu_rvalid = 1'b0;
    check("abort_refetch", ifu_arvalid, 1);
    check("abort_refetch_addr", ifu_araddr, RST_PC);
    check("abort_no_out", out_valid, 0);
    run_txn(0, 1, 32'h0000_0013, 2'b00, 1, 0, 32'h8000_0100);

    repeat (3) step();
    check("handshake_count", 32'(hs_count), 32'(exp_hs));
    check("queue_drained", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
